// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl: turns an rx byte stream into register file write/read frames and returns read data on tx
// Frames: WRITE = {WR_CMD, addr, data}; READ = {RD_CMD, addr} -> one byte on tx_data/tx_valid.
// Ports: clk, rst (async active-low); rx_data/rx_valid byte input;
//   WrData/Address/Wr_En/Rd_EN/Rd_Data register file side (1-cycle registered read);
//   tx_data/tx_valid/tx_ready read-back handshake; busy, cmd_err, rx_drop status.
// Optional feature: define CMD_TIMEOUT_EN to abort frames idle for TIMEOUT_CYCLES cycles.
module reg_file_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD = 8'hBB,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  Wr_En,
  output logic                  Rd_EN,
  input  logic [DATA_WIDTH-1:0] Rd_Data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  rx_drop
);
  // RD_REQ is the cycle Rd_EN is high; RD_WAIT is the cycle Rd_Data becomes valid
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, RD_SEND} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] wdata_n, txd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic wr_n, rd_n, txv_n, err_n, drop_n;
`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic in_frame, timed_out;
  assign in_frame = state inside {WR_ADDR, WR_DATA, RD_ADDR};
  // fires on the TIMEOUT_CYCLES-th consecutive silent cycle of a frame
  assign timed_out = in_frame && !rx_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_n = (in_frame && !rx_valid && !timed_out) ? cnt + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    addr_n = Address;
    wdata_n = WrData;
    txd_n = tx_data;
    txv_n = tx_valid;
    wr_n = 1'b0;
    rd_n = 1'b0;
    err_n = 1'b0;
    drop_n = rx_valid && state inside {RD_REQ, RD_WAIT, RD_SEND};
    case (state)
      IDLE: if (rx_valid) begin
        state_n = rx_data == WR_CMD ? WR_ADDR : rx_data == RD_CMD ? RD_ADDR : IDLE;
        err_n = rx_data != WR_CMD && rx_data != RD_CMD;
      end
      WR_ADDR: if (rx_valid) begin
        addr_n = rx_data[ADDR_WIDTH-1:0];
        state_n = WR_DATA;
      end
      WR_DATA: if (rx_valid) begin
        wdata_n = rx_data;
        wr_n = 1'b1;
        state_n = IDLE;
      end
      RD_ADDR: if (rx_valid) begin
        addr_n = rx_data[ADDR_WIDTH-1:0];
        rd_n = 1'b1;
        state_n = RD_REQ;
      end
      RD_REQ: state_n = RD_WAIT;
      RD_WAIT: begin
        txd_n = Rd_Data;
        txv_n = 1'b1;
        state_n = RD_SEND;
      end
      RD_SEND: if (tx_ready) begin
        txv_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef CMD_TIMEOUT_EN
    if (timed_out) begin
      state_n = IDLE;
      err_n = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      Address <= '0;
      WrData <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      Wr_En <= 1'b0;
      Rd_EN <= 1'b0;
      cmd_err <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      state <= state_n;
      Address <= addr_n;
      WrData <= wdata_n;
      tx_data <= txd_n;
      tx_valid <= txv_n;
      Wr_En <= wr_n;
      Rd_EN <= rd_n;
      cmd_err <= err_n;
      rx_drop <= drop_n;
    end
endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb_reg_file_cmd_ctrl: directed and randomized frames checked against a frame-level register model
module tb_reg_file_cmd_ctrl;
  localparam logic [7:0] WR = 8'hAA, RD = 8'hBB;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] rx_data = '0, WrData, tx_data, Rd_Data = '0;
  logic [3:0] Address;
  logic rx_valid = 1'b0, tx_ready = 1'b0;
  logic Wr_En, Rd_EN, tx_valid, busy, cmd_err, rx_drop;
  logic [7:0] rf [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  int total = 0, bad = 0;

  reg_file_cmd_ctrl #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .WrData(WrData), .Address(Address), .Wr_En(Wr_En), .Rd_EN(Rd_EN), .Rd_Data(Rd_Data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cmd_err(cmd_err), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // register file with 1-cycle registered read
  always @(posedge clk) begin
    if (Wr_En) rf[Address] <= WrData;
    if (Rd_EN) Rd_Data <= rf[Address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    send(WR);
    idle(gap);
    send(a);
    idle(gap);
    send(d);
    chk("wr_en", Wr_En, 1);
    chk("wr_addr", Address, a[3:0]);
    chk("wr_data", WrData, d);
    chk("wr_busy", busy, 0);
    chk("wr_no_rd", Rd_EN, 0);
    ref_mem[a[3:0]] = d;
    step();
    chk("wr_pulse", Wr_En, 0);
    chk("wr_hold_data", WrData, d);
  endtask

  task automatic do_read(input logic [7:0] a, input int gap, input int hold, input bit drop);
    logic [7:0] exp;
    exp = ref_mem[a[3:0]];
    send(RD);
    idle(gap);
    send(a);
    chk("rd_en", Rd_EN, 1);
    chk("rd_no_wr", Wr_En, 0);
    chk("rd_addr", Address, a[3:0]);
    step();
    chk("rd_pulse", Rd_EN, 0);
    chk("rd_early_tx", tx_valid, 0);
    step();
    chk("tx_valid", tx_valid, 1);
    chk("tx_data", tx_data, exp);
    for (int i = 0; i < hold; i++) begin
      if (drop && i == 0) begin
        send(8'($urandom));
        chk("rx_drop", rx_drop, 1);
      end else begin
        step();
        chk("rx_drop_pulse", rx_drop, 0);
      end
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, exp);
      chk("tx_hold_busy", busy, 1);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_done", tx_valid, 0);
    chk("rd_idle", busy, 0);
  endtask

  initial begin
    idle(2);
    chk("rst_wr_en", Wr_En, 0);
    chk("rst_rd_en", Rd_EN, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wdata", WrData, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cmd_err, 0);
    rst = 1'b1;
    idle(2);
    do_write(8'h03, 8'h5C, 0);
    do_read(8'h03, 0, 5, 1'b0);
    send(8'h12);
    chk("err_pulse", cmd_err, 1);
    chk("err_busy", busy, 0);
    chk("err_no_wr", Wr_En, 0);
    chk("err_no_rd", Rd_EN, 0);
    step();
    chk("err_once", cmd_err, 0);
    do_write(8'h0F, 8'hFF, 0);
    do_read(8'hF3, 1, 3, 1'b1);
    // reset in the middle of a write frame
    send(WR);
    send(8'h09);
    rst = 1'b0;
    #1;
    chk("arst_addr", Address, 0);
    chk("arst_wdata", WrData, 0);
    chk("arst_txd", tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr", Wr_En, 0);
    step();
    rst = 1'b1;
    step();
    send(8'h55);
    chk("post_rst_no_wr", Wr_En, 0);
    chk("post_rst_err", cmd_err, 1);
    chk("post_rst_busy", busy, 0);
    step();
    chk("post_rst_no_wr2", Wr_En, 0);
    // silence inside a frame
    send(WR);
    idle(10);
`ifdef CMD_TIMEOUT_EN
    chk("to_err", cmd_err, 1);
    chk("to_busy", busy, 0);
    chk("to_no_wr", Wr_En, 0);
    step();
    chk("to_err_once", cmd_err, 0);
`else
    chk("no_to_busy", busy, 1);
    chk("no_to_err", cmd_err, 0);
    send(8'h06);
    send(8'h3C);
    chk("late_wr", Wr_En, 1);
    ref_mem[6] = 8'h3C;
    step();
`endif
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) do_write(8'($urandom), 8'($urandom), $urandom_range(0, 3));
      else if (kind < 9) do_read(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
      else begin
        send(8'($urandom_range(0, 8'hA9)));
        chk("rnd_err", cmd_err, 1);
        chk("rnd_err_busy", busy, 0);
      end
      idle($urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
